// File: rtl/key_event_sequencer.sv
// key_event_sequencer
//   Avalon-MM master for a KEY_W-bit edge-capture PIO. After reset it programs the
//   irq mask and clears stale captures. On each PIO irq it reads edge_capture, clears
//   it, and turns every captured key edge into a one-key event in a small FIFO. A
//   hold-off follows each service pass to debounce the keys.
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   enable                        1 = service irqs; 0 = finish the current pass, then idle
//   pio_irq                       PIO interrupt (level)
//   pio_readdata                  PIO read data, valid one cycle after the address
//   pio_address/chipselect/
//   pio_write_n/pio_writedata     PIO bus (2 = irq_mask, 3 = edge_capture)
//   evt_valid/evt_key/evt_ready   event FIFO head with valid/ready pop
//   overflow/ovf_clr              sticky drop flag and its synchronous clear
module key_event_sequencer #(
    parameter int unsigned      KEY_W      = 4,
    parameter int unsigned      FIFO_DEPTH = 4,
    parameter int unsigned      HOLDOFF    = 500000,
    parameter logic [KEY_W-1:0] MASK_INIT  = '1,
    localparam int unsigned     KIDX_W     = (KEY_W > 1) ? $clog2(KEY_W) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              pio_irq,
    input  logic [31:0]       pio_readdata,
    output logic [1:0]        pio_address,
    output logic              pio_chipselect,
    output logic              pio_write_n,
    output logic [31:0]       pio_writedata,
    output logic              evt_valid,
    output logic [KIDX_W-1:0] evt_key,
    input  logic              evt_ready,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned HOLD_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int unsigned HOLD_LOAD = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;
    localparam logic [1:0]  ADDR_MASK = 2'd2;
    localparam logic [1:0]  ADDR_CAP  = 2'd3;
    localparam logic [31:0] CLR_DATA  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_INIT, S_CLR0, S_IDLE, S_RDREQ, S_RDCAP, S_PUSH, S_HOLD
    } state_e;

    state_e              state_q, state_d;
    logic [KEY_W-1:0]    pend_q, pend_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [1:0]          addr_q, addr_d;
    logic                cs_q, cs_d;
    logic                wn_q, wn_d;
    logic [31:0]         wd_q, wd_d;

    logic [KIDX_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                evt_valid_q;
    logic [KIDX_W-1:0]   evt_key_q, evt_key_d;
    logic                overflow_q;

    logic                push, enter_hold, pop, full, push_ok, drop;
    logic [KIDX_W-1:0]   push_key;
    logic                unused_rd;

    assign unused_rd = ^pio_readdata[31:KEY_W];

    // Lowest set pending bit is the next key to emit.
    always_comb begin
        push_key = '0;
        for (int i = KEY_W - 1; i >= 0; i--) begin
            if (pend_q[i]) push_key = KIDX_W'(i);
        end
    end

    // Next state and next bus access; bus outputs track the state being entered.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        hold_d     = hold_q;
        cs_d       = 1'b0;
        wn_d       = 1'b1;
        addr_d     = 2'd0;
        wd_d       = '0;
        push       = 1'b0;
        enter_hold = 1'b0;
        case (state_q)
            S_INIT: begin
                // Reset leaves the bus idle, so INIT spends one cycle presenting the mask write.
                cs_d = 1'b1;
                wn_d = 1'b0;
                if (!cs_q) begin
                    addr_d = ADDR_MASK;
                    wd_d   = 32'(MASK_INIT);
                end else begin
                    state_d = S_CLR0;
                    addr_d  = ADDR_CAP;
                    wd_d    = CLR_DATA;
                end
            end
            S_CLR0: state_d = S_IDLE;
            S_IDLE: begin
                if (pio_irq && enable) begin
                    state_d = S_RDREQ;
                    cs_d    = 1'b1;
                    addr_d  = ADDR_CAP;
                end
            end
            S_RDREQ: begin
                // Clear write rides on the same cycle the capture data is latched.
                state_d = S_RDCAP;
                cs_d    = 1'b1;
                wn_d    = 1'b0;
                addr_d  = ADDR_CAP;
                wd_d    = CLR_DATA;
            end
            S_RDCAP: begin
                pend_d = pio_readdata[KEY_W-1:0];
                if (pio_readdata[KEY_W-1:0] == '0) enter_hold = 1'b1;
                else                               state_d = S_PUSH;
            end
            S_PUSH: begin
                push   = 1'b1;
                pend_d = pend_q & (pend_q - KEY_W'(1));
                if (pend_d == '0) enter_hold = 1'b1;
            end
            S_HOLD: begin
                if (hold_q == '0) state_d = S_IDLE;
                else              hold_d  = hold_q - HOLD_W'(1);
            end
            default: state_d = S_INIT;
        endcase
        if (enter_hold) begin
            if (HOLDOFF == 0) begin
                state_d = S_IDLE;
            end else begin
                state_d = S_HOLD;
                hold_d  = HOLD_W'(HOLD_LOAD);
            end
        end
    end

    // FIFO bookkeeping; a pop frees room for a same-cycle push when full.
    always_comb begin
        pop       = evt_valid_q && evt_ready;
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        push_ok   = push && (!full || pop);
        drop      = push && full && !pop;
        count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        evt_key_d = evt_key_q;
        if (pop && (count_q > CNT_W'(1))) begin
            evt_key_d = mem_q[rd_ptr_q + PTR_W'(1)];
        end else if (push_ok && ((count_q == '0) || (pop && (count_q == CNT_W'(1))))) begin
            evt_key_d = push_key;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_INIT;
            pend_q      <= '0;
            hold_q      <= '0;
            cs_q        <= 1'b0;
            wn_q        <= 1'b1;
            addr_q      <= 2'd0;
            wd_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            evt_valid_q <= 1'b0;
            evt_key_q   <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            hold_q      <= hold_d;
            cs_q        <= cs_d;
            wn_q        <= wn_d;
            addr_q      <= addr_d;
            wd_q        <= wd_d;
            count_q     <= count_d;
            evt_valid_q <= (count_d != '0);
            evt_key_q   <= evt_key_d;
            overflow_q  <= ovf_clr ? 1'b0 : (overflow_q | drop);
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_key;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    assign pio_address    = addr_q;
    assign pio_chipselect = cs_q;
    assign pio_write_n    = wn_q;
    assign pio_writedata  = wd_q;
    assign evt_valid      = evt_valid_q;
    assign evt_key        = evt_key_q;
    assign overflow       = overflow_q;

endmodule
